// File: rtl/if_stage_pkg.sv
// -----------------------------------------------------------------------------
// if_stage_pkg
// Shared types and constants for the instruction-fetch stage and its consumers.
//   if_id_flow_t     : {pc, instr} record handed from fetch to decode
//   NOP_INSTR        : instruction shown on outflow while nothing valid is queued
//   DEFAULT_RESET_PC : default first fetch address after reset
// -----------------------------------------------------------------------------
package if_stage_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_flow_t;

endpackage

// File: rtl/if_stage_if.sv
// -----------------------------------------------------------------------------
// if_stage_if
// Instruction-memory bus between the fetch stage (master) and memory (slave).
//   req_valid/req_ready/req_addr : fetch request channel
//   resp_valid/resp_data         : in-order response channel, no back-pressure
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both high. req_addr is only meaningful while req_valid is high.
// Responses return in request order, at least one cycle after acceptance, and
// each is presented for exactly one cycle with resp_valid high.
// -----------------------------------------------------------------------------
interface if_stage_if;
  import if_stage_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  resp_valid,
    input  resp_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output resp_valid,
    output resp_data
  );

endinterface

// File: rtl/if_stage_fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Generic synchronous FIFO with flush.
//   clk, reset : clock, asynchronous active-high reset
//   push       : write push_data at the tail
//   pop        : drop the head entry (caller guarantees count != 0)
//   flush      : empty the FIFO; wins over push and pop in the same cycle
//   count      : number of stored entries (0..DEPTH)
//   head       : oldest entry; undefined while count == 0
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module fetch_queue #(
  parameter int W     = 32,
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [CW-1:0] count,
  output logic [W-1:0]  head
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Storage needs no reset: count gates every use of head.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// Instruction fetch: generates the PC, issues in-order requests on the imem
// bus, buffers returned words and presents one {pc, instr} per cycle to decode.
// A redirect from execute discards everything queued or in flight.
//
// Ports
//   clk, reset       : clock, asynchronous active-high reset
//   stall            : decode cannot accept; hold outflow
//   redirect_valid   : control-flow change from execute (beats stall/request/pop)
//   redirect_pc      : redirect target, word aligned
//   imem             : if_stage_if.master, instruction-memory request/response
//   out_valid        : outflow carries a real instruction
//   outflow          : {pc, instr}; {last pc, NOP} while nothing is queued
//   bubble_cnt       : only with IF_PERF_CNT_EN defined; counts cycles with
//                      !out_valid && !stall, wraps at 2^32
//
// Parameters: RESET_PC (first fetch address), QDEPTH (queue entries, power of
// two, >= 2).
// -----------------------------------------------------------------------------
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          QDEPTH   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  if_stage_if.master        imem,
  output logic              out_valid,
  output if_id_flow_t       outflow
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       bubble_cnt
`endif
);

  localparam int CW = $clog2(QDEPTH) + 1;
  // One spare bit: back-to-back redirects under long memory latency can stack
  // stale responses beyond QDEPTH before they drain.
  localparam int DW = CW + 1;
  localparam logic [DW-1:0] CREDIT = DW'(QDEPTH);

  logic [31:0]   pc_q;
  logic [31:0]   last_pc;
  logic [DW-1:0] drop_cnt;
  logic [CW-1:0] in_flight;
  logic [CW-1:0] q_count;
  logic [31:0]   tag_pc;
  if_id_flow_t   q_head;
  if_id_flow_t   q_push_data;
  logic          req_fire;
  logic          resp_keep;
  logic          resp_drop;
  logic          q_push;
  logic          q_pop;
  logic [DW-1:0] used;

  assign out_valid = (q_count != '0);
  assign q_pop     = out_valid && !stall && !redirect_valid;

  // Credits: a slot being popped this cycle is already free, which is what
  // sustains one instruction per cycle with a 1-cycle memory and QDEPTH = 2.
  assign used = DW'(in_flight) + DW'(q_count) - DW'(q_pop);

  // Requests pause while too many stale responses are outstanding so that
  // drop_cnt can never overflow.
  assign imem.req_valid = !reset && !redirect_valid &&
                          (used < CREDIT) && (drop_cnt <= CREDIT);
  assign imem.req_addr  = pc_q;

  assign req_fire  = imem.req_valid && imem.req_ready;
  assign resp_keep = imem.resp_valid && (drop_cnt == '0);
  assign resp_drop = imem.resp_valid && (drop_cnt != '0);
  assign q_push    = resp_keep && !redirect_valid;
  assign q_push_data = {tag_pc, imem.resp_data};

  fetch_queue #(.W($bits(if_id_flow_t)), .DEPTH(QDEPTH)) u_instr_q (
    .clk       (clk),
    .reset     (reset),
    .push      (q_push),
    .push_data (q_push_data),
    .pop       (q_pop),
    .flush     (redirect_valid),
    .count     (q_count),
    .head      (q_head)
  );

  // PC tags of accepted, not-yet-answered requests; its occupancy is the
  // in-flight count (cleared on redirect, the stale ones move to drop_cnt).
  fetch_queue #(.W(32), .DEPTH(QDEPTH)) u_tag_q (
    .clk       (clk),
    .reset     (reset),
    .push      (req_fire),
    .push_data (pc_q),
    .pop       (resp_keep),
    .flush     (redirect_valid),
    .count     (in_flight),
    .head      (tag_pc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      last_pc  <= RESET_PC;
      drop_cnt <= '0;
    end else begin
      if (out_valid) last_pc <= q_head.pc;
      if (redirect_valid) begin
        pc_q     <= redirect_pc;
        // Whatever response arrives now (kept or dropped) is already counted.
        drop_cnt <= drop_cnt + DW'(in_flight) - DW'(imem.resp_valid);
      end else begin
        if (req_fire)  pc_q     <= pc_q + 32'd4;
        if (resp_drop) drop_cnt <= drop_cnt - DW'(1);
      end
    end
  end

  always_comb begin
    outflow = q_head;
    if (!out_valid) begin
      outflow.pc    = last_pc;
      outflow.instr = NOP_INSTR;
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   bubble_cnt <= '0;
    else if (!out_valid && !stall) bubble_cnt <= bubble_cnt + 32'd1;
  end
`endif

  assert property (@(posedge clk) disable iff (reset)
                   imem.resp_valid |-> (in_flight != '0 || drop_cnt != '0))
    else $error("if_stage: imem response with no outstanding request");

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage
// Directed bench for if_stage: a per-cycle vector table with a 1-cycle memory,
// then hand-written sequences (redirect with two requests in flight, random
// ready with 3-cycle latency) checked against an expected-PC queue.
// -----------------------------------------------------------------------------
module tb_if_stage;
  import if_stage_pkg::*;

  localparam logic [31:0] NOP = NOP_INSTR;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  if_id_flow_t outflow;
`ifdef IF_PERF_CNT_EN
  logic [31:0] bubble_cnt;
`endif

  if_stage_if imem_bus();

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (imem_bus),
`ifdef IF_PERF_CNT_EN
    .bubble_cnt     (bubble_cnt),
`endif
    .out_valid      (out_valid),
    .outflow        (outflow)
  );

  // ---------------- memory model / scoreboard state ----------------
  int          n_vec = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          lat = 1;
  int          rnd_ready = 0;
  int          mon_en = 0;
  int          delivered = 0;
  logic [31:0] pend_addr[$];
  int          pend_cyc[$];
  logic [31:0] exp_q[$];

  typedef struct {
    logic        st;
    logic        rv;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_ov;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t tbl [21];

  function automatic vec_t mk(input logic st, input logic rv, input logic [31:0] rpc,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic e_ov, input logic [31:0] e_pc,
                              input logic [31:0] e_instr);
    vec_t v;
    v.st = st; v.rv = rv; v.rpc = rpc;
    v.e_req = e_req; v.e_addr = e_addr;
    v.e_ov = e_ov; v.e_pc = e_pc; v.e_instr = e_instr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_mem();
    if (pend_addr.size() > 0 && pend_cyc[0] + lat <= cyc) begin
      imem_bus.resp_valid = 1'b1;
      imem_bus.resp_data  = pend_addr[0] + 32'h100;
    end else begin
      imem_bus.resp_valid = 1'b0;
      imem_bus.resp_data  = '0;
    end
    imem_bus.req_ready = (rnd_ready != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic set_in(input logic st, input logic rv, input logic [31:0] rp);
    stall = st;
    redirect_valid = rv;
    redirect_pc = rp;
    #1;
  endtask

  // Scoreboard check of the delivered stream, then one clock edge.
  task automatic advance();
    logic        fire;
    logic        rdone;
    logic [31:0] a;
    fire  = imem_bus.req_valid && imem_bus.req_ready;
    rdone = imem_bus.resp_valid;
    a     = imem_bus.req_addr;
    if (mon_en != 0 && out_valid && !stall) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL stream_extra cyc=%0d got pc=%h want none", cyc, outflow.pc);
      end else begin
        chk("stream_pc", outflow.pc, exp_q[0]);
        chk("stream_instr", outflow.instr, exp_q[0] + 32'h100);
        void'(exp_q.pop_front());
        delivered++;
      end
    end
    @(posedge clk);
    #1;
    if (rdone) begin
      void'(pend_addr.pop_front());
      void'(pend_cyc.pop_front());
    end
    if (fire) begin
      pend_addr.push_back(a);
      pend_cyc.push_back(cyc);
    end
    cyc++;
    drive_mem();
  endtask

  task automatic hold_reset();
    reset = 1'b1;
    pend_addr.delete();
    pend_cyc.delete();
    imem_bus.resp_valid = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 1;
    drive_mem();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- test ----------------
  initial begin
    // cycle-by-cycle vectors, 1-cycle memory, always ready; entry i = cycle i+1
    tbl[0]  = mk(0, 0, 0,        1, 32'h00, 0, 32'h00, NOP);
    tbl[1]  = mk(0, 0, 0,        1, 32'h04, 0, 32'h00, NOP);
    tbl[2]  = mk(0, 0, 0,        1, 32'h08, 1, 32'h00, 32'h100);
    tbl[3]  = mk(0, 0, 0,        1, 32'h0C, 1, 32'h04, 32'h104);
    tbl[4]  = mk(0, 0, 0,        1, 32'h10, 1, 32'h08, 32'h108);
    for (int i = 5; i < 10; i++)
      tbl[i] = mk(1, 0, 0,       0, 32'h00, 1, 32'h0C, 32'h10C);
    tbl[10] = mk(0, 0, 0,        1, 32'h14, 1, 32'h0C, 32'h10C);
    tbl[11] = mk(0, 0, 0,        1, 32'h18, 1, 32'h10, 32'h110);
    tbl[12] = mk(1, 1, 32'h80,   0, 32'h00, 1, 32'h14, 32'h114);
    tbl[13] = mk(0, 0, 0,        1, 32'h80, 0, 32'h14, NOP);
    tbl[14] = mk(0, 0, 0,        1, 32'h84, 0, 32'h14, NOP);
    tbl[15] = mk(0, 0, 0,        1, 32'h88, 1, 32'h80, 32'h180);
    tbl[16] = mk(0, 1, 32'h40,   0, 32'h00, 1, 32'h84, 32'h184);
    tbl[17] = mk(0, 0, 0,        1, 32'h40, 0, 32'h84, NOP);
    tbl[18] = mk(0, 0, 0,        1, 32'h44, 0, 32'h84, NOP);
    tbl[19] = mk(0, 0, 0,        1, 32'h48, 1, 32'h40, 32'h140);
    tbl[20] = mk(0, 0, 0,        1, 32'h4C, 1, 32'h44, 32'h144);

    imem_bus.req_ready  = 1'b1;
    imem_bus.resp_valid = 1'b0;
    imem_bus.resp_data  = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_valid", 32'(imem_bus.req_valid), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_pc", outflow.pc, 32'h0);
    chk("rst_instr", outflow.instr, NOP);

    // table-driven main sequence
    lat = 1; rnd_ready = 0; mon_en = 0;
    release_reset();
    for (int i = 0; i < 21; i++) begin
      set_in(tbl[i].st, tbl[i].rv, tbl[i].rpc);
      chk($sformatf("t%0d_req_valid", i + 1), 32'(imem_bus.req_valid), 32'(tbl[i].e_req));
      if (tbl[i].e_req) chk($sformatf("t%0d_req_addr", i + 1), imem_bus.req_addr, tbl[i].e_addr);
      chk($sformatf("t%0d_out_valid", i + 1), 32'(out_valid), 32'(tbl[i].e_ov));
      chk($sformatf("t%0d_pc", i + 1), outflow.pc, tbl[i].e_pc);
      chk($sformatf("t%0d_instr", i + 1), outflow.instr, tbl[i].e_instr);
      advance();
    end
`ifdef IF_PERF_CNT_EN
    chk("bubble_cnt", bubble_cnt, 32'd6);
`endif

    // reset mid-operation clears state at once (queue holds entries here)
    hold_reset();
    chk("midrst_req_valid", 32'(imem_bus.req_valid), 0);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_pc", outflow.pc, 32'h0);
    chk("midrst_instr", outflow.instr, NOP);
`ifdef IF_PERF_CNT_EN
    chk("midrst_bubble_cnt", bubble_cnt, 32'd0);
`endif

    // redirect to 0x80 with two requests in flight, 3-cycle memory
    lat = 3; rnd_ready = 0;
    release_reset();
    exp_q.delete();
    for (int k = 0; k < 16; k++) exp_q.push_back(32'h80 + 32'(4 * k));
    delivered = 0;
    mon_en = 1;
    set_in(0, 0, 0);
    chk("a_c1_req_addr", imem_bus.req_addr, 32'h0);
    advance();
    set_in(0, 0, 0);
    chk("a_c2_req_addr", imem_bus.req_addr, 32'h4);
    advance();
    set_in(0, 1, 32'h80);
    chk("a_redirect_no_req", 32'(imem_bus.req_valid), 0);
    advance();
    set_in(0, 0, 0);
    chk("a_t1_req_valid", 32'(imem_bus.req_valid), 1);
    chk("a_t1_req_addr", imem_bus.req_addr, 32'h80);
    chk("a_t1_out_valid", 32'(out_valid), 0);
    advance();
    for (int c = 0; c < 3; c++) begin
      set_in(0, 0, 0);
      chk("a_gap_out_valid", 32'(out_valid), 0);
      advance();
    end
    set_in(0, 0, 0);
    chk("a_first_out_valid", 32'(out_valid), 1);
    chk("a_first_pc", outflow.pc, 32'h80);
    advance();
    repeat (12) begin
      set_in(0, 0, 0);
      advance();
    end
    chk("a_delivered_ge4", 32'(delivered >= 4), 1);

    // ready toggling at random, 3-cycle latency, occasional stall
    hold_reset();
    lat = 3; rnd_ready = 1;
    release_reset();
    exp_q.delete();
    for (int k = 0; k < 400; k++) exp_q.push_back(32'(4 * k));
    delivered = 0;
    mon_en = 1;
    for (int c = 0; c < 300; c++) begin
      set_in(1'($urandom_range(0, 3) == 0), 0, 0);
      advance();
    end
    chk("b_delivered_ge20", 32'(delivered >= 20), 1);
    mon_en = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
